// File: rtl/hazard_ctl_pkg.sv
// -----------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the WISC-SP13 pipeline hazard logic.
//   REG_W            register specifier width
//   RS_HI..RT_LO     bit positions of the rs / rt fields in a 16-bit instruction
//   NOP_INSTR        NOP encoding injected into EX when the pipe stalls
//   sb_entry_t       one scoreboard slot: {valid, destination register}
//   SB_INVALID       empty scoreboard slot (reset / bubble value)
//   entry_match()    true when a slot holds a live write to a given register
// -----------------------------------------------------------------------------
package wisc_pkg;

  localparam int REG_W = 3;

  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

  localparam logic [15:0] NOP_INSTR = 16'b00001_00000000000;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rg;
  } sb_entry_t;

  localparam sb_entry_t SB_INVALID = '{valid: 1'b0, rg: 3'd0};

  // A slot only matches while it carries a pending write; R0 is a real
  // register in this ISA, so no special case for register 0.
  function automatic logic entry_match(input sb_entry_t e,
                                       input logic [REG_W-1:0] r);
    return e.valid & (e.rg == r);
  endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctl_if
// Bundles the ID-stage inputs, pipeline controls and hazard outputs of
// hazard_ctl.
//   master : drives ID instruction info, pipe_en and flush; observes results
//   slave  : the hazard controller itself
// Signals:
//   id_instr[15:0]  instruction in ID (rs = [10:8], rt = [7:5])
//   id_rs_used      ID instruction reads rs
//   id_rt_used      ID instruction reads rt
//   id_reg_write    ID instruction writes the register file
//   id_wr_reg[2:0]  destination register of the ID instruction
//   pipe_en         global pipeline advance
//   flush           branch/jump taken in EX
//   stall           inject NOP into EX
//   ifid_en         IF/ID register enable
//   pc_en           PC register enable
//   sb_busy         any scoreboard entry valid
//   stall_cycles    saturating count of stalled, advancing cycles
// -----------------------------------------------------------------------------
interface hazard_ctl_if #(
  parameter int CNT_W = 16
);

  logic [15:0]      id_instr;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_reg_write;
  logic [2:0]       id_wr_reg;
  logic             pipe_en;
  logic             flush;
  logic             stall;
  logic             ifid_en;
  logic             pc_en;
  logic             sb_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_instr,
    output id_rs_used,
    output id_rt_used,
    output id_reg_write,
    output id_wr_reg,
    output pipe_en,
    output flush,
    input  stall,
    input  ifid_en,
    input  pc_en,
    input  sb_busy,
    input  stall_cycles
  );

  modport slave (
    input  id_instr,
    input  id_rs_used,
    input  id_rt_used,
    input  id_reg_write,
    input  id_wr_reg,
    input  pipe_en,
    input  flush,
    output stall,
    output ifid_en,
    output pc_en,
    output sb_busy,
    output stall_cycles
  );

endinterface

// File: rtl/hazard_ctl_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Compares one ID source register against the in-flight writers held in the
// scoreboard and flags a RAW hazard.
//   WB_BYPASS  1: the register file writes before it reads, so WB is ignored
//   src_reg    source register specifier from the ID instruction
//   src_used   the ID instruction actually reads src_reg
//   ex_e       scoreboard slot for the EX stage
//   mem_e      scoreboard slot for the MEM stage
//   wb_e       scoreboard slot for the WB stage
//   hit        RAW hazard on this source
// -----------------------------------------------------------------------------
module hazard_cmp
  import wisc_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic [REG_W-1:0] src_reg,
  input  logic             src_used,
  input  sb_entry_t        ex_e,
  input  sb_entry_t        mem_e,
  input  sb_entry_t        wb_e,
  output logic             hit
);

  logic wb_chk_s;

  // Match the source against every checked slot; WB drops out under bypass.
  always_comb begin
    if (WB_BYPASS) begin
      wb_chk_s = 1'b0;
    end else begin
      wb_chk_s = entry_match(wb_e, src_reg);
    end
    hit = src_used & (entry_match(ex_e, src_reg) |
                      entry_match(mem_e, src_reg) |
                      wb_chk_s);
  end

endmodule

// File: rtl/hazard_ctl.sv
// -----------------------------------------------------------------------------
// hazard_ctl
// RAW hazard controller for the five-stage WISC-SP13 core (no forwarding).
// A three-slot scoreboard mirrors the destination registers of the
// instructions in EX, MEM and WB; the instruction in ID is stalled while any
// checked slot holds a pending write to one of its sources.
// Parameters:
//   WB_BYPASS  1: WB slot never causes a hazard; 0: WB slot is checked too
//   CNT_W      width of the stall statistics counter
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   hazard_ctl_if.slave (ID info, pipe_en, flush, stall outputs, stats)
// -----------------------------------------------------------------------------
module hazard_ctl
  import wisc_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sb_entry_t        ex_r;
  sb_entry_t        mem_r;
  sb_entry_t        wb_r;
  sb_entry_t        ex_nxt_s;
  logic [CNT_W-1:0] cnt_r;

  logic [REG_W-1:0] rs_s;
  logic [REG_W-1:0] rt_s;
  logic             rs_hit_s;
  logic             rt_hit_s;
  logic             haz_s;
  logic             stall_s;
  logic             unused_instr_s;

  assign rs_s = bus.id_instr[RS_HI:RS_LO];
  assign rt_s = bus.id_instr[RT_HI:RT_LO];

  // Opcode/function bits carry no register information for hazard purposes.
  assign unused_instr_s = ^{bus.id_instr[15:11], bus.id_instr[4:0]};

  hazard_cmp #(
    .WB_BYPASS (WB_BYPASS)
  ) u_cmp_rs (
    .src_reg  (rs_s),
    .src_used (bus.id_rs_used),
    .ex_e     (ex_r),
    .mem_e    (mem_r),
    .wb_e     (wb_r),
    .hit      (rs_hit_s)
  );

  hazard_cmp #(
    .WB_BYPASS (WB_BYPASS)
  ) u_cmp_rt (
    .src_reg  (rt_s),
    .src_used (bus.id_rt_used),
    .ex_e     (ex_r),
    .mem_e    (mem_r),
    .wb_e     (wb_r),
    .hit      (rt_hit_s)
  );

  // Stall decision; a flushed ID instruction is squashed, so it must never
  // hold the pipe even when it would otherwise hazard.
  always_comb begin
    haz_s   = rs_hit_s | rt_hit_s;
    stall_s = haz_s & ~bus.flush;
  end

  // Value entering the EX slot: a bubble on stall/flush or for non-writers.
  always_comb begin
    ex_nxt_s = SB_INVALID;
    if (stall_s | bus.flush | ~bus.id_reg_write) begin
      ex_nxt_s = SB_INVALID;
    end else begin
      ex_nxt_s = '{valid: 1'b1, rg: bus.id_wr_reg};
    end
  end

  // Scoreboard shift register; frozen entirely while the pipe is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r  <= SB_INVALID;
      mem_r <= SB_INVALID;
      wb_r  <= SB_INVALID;
    end else if (bus.pipe_en) begin
      ex_r  <= ex_nxt_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end else begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end
  end

  // Stall statistics: counts only cycles that really lose an issue slot,
  // and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (bus.pipe_en & stall_s & (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Outputs. stall must react to ID inputs in the same cycle, and the
  // scoreboard-derived terms drop as soon as rst clears the slots.
  always_comb begin
    bus.stall        = stall_s;
    bus.ifid_en      = bus.pipe_en & ~stall_s;
    bus.pc_en        = bus.pipe_en & ~stall_s;
    bus.sb_busy      = ex_r.valid | mem_r.valid | wb_r.valid;
    bus.stall_cycles = cnt_r;
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctl
// Drives three hazard_ctl instances with identical ID streams:
//   u_dut1 : WB_BYPASS = 1, CNT_W = 16
//   u_dut0 : WB_BYPASS = 0, CNT_W = 16
//   u_duts : WB_BYPASS = 1, CNT_W = 2 (counter saturation)
// The reference keeps a history of the instructions actually issued into EX
// (newest first); an ID source hazards when one of the most recent 2 (bypass)
// or 3 (no bypass) issued writers targets it.
// -----------------------------------------------------------------------------
module tb_hazard_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hazard_ctl_if #(.CNT_W(16)) if1 ();
  hazard_ctl_if #(.CNT_W(16)) if0 ();
  hazard_ctl_if #(.CNT_W(2))  ifs ();

  hazard_ctl #(.WB_BYPASS(1'b1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  hazard_ctl #(.WB_BYPASS(1'b0), .CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  hazard_ctl #(.WB_BYPASS(1'b1), .CNT_W(2))  u_duts (.clk(clk), .rst(rst), .bus(ifs));

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: issued-instruction history, bit 3 = writes, [2:0] = reg
  logic [3:0] hq1[$];
  logic [3:0] hq0[$];
  int unsigned cnt1 = 0;
  int unsigned cnt0 = 0;
  logic last_st1, last_st0;
  int seen1, seen0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_haz(input logic [3:0] q[$], input int depth, input logic [2:0] r);
    for (int i = 0; i < q.size() && i < depth; i++)
      if (q[i][3] && q[i][2:0] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_busy(input logic [3:0] q[$]);
    for (int i = 0; i < q.size(); i++)
      if (q[i][3]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic [2:0] rs, input logic [2:0] rt, input logic rs_u,
                       input logic rt_u, input logic rw, input logic [2:0] wr,
                       input logic pe, input logic fl);
    logic [31:0] junk;
    logic [15:0] ins;
    junk = $urandom_range(31, 0);
    ins  = {5'b11011, rs, rt, junk[4:0]};
    if1.id_instr = ins; if1.id_rs_used = rs_u; if1.id_rt_used = rt_u;
    if1.id_reg_write = rw; if1.id_wr_reg = wr; if1.pipe_en = pe; if1.flush = fl;
    if0.id_instr = ins; if0.id_rs_used = rs_u; if0.id_rt_used = rt_u;
    if0.id_reg_write = rw; if0.id_wr_reg = wr; if0.pipe_en = pe; if0.flush = fl;
    ifs.id_instr = ins; ifs.id_rs_used = rs_u; ifs.id_rt_used = rt_u;
    ifs.id_reg_write = rw; ifs.id_wr_reg = wr; ifs.pipe_en = pe; ifs.flush = fl;
  endtask

  function automatic int unsigned sat3(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  // One cycle: drive at the falling edge, check 1 time unit later, advance model
  // at the rising edge, return at the next falling edge.
  task automatic step(input logic [2:0] rs, input logic [2:0] rt, input logic rs_u,
                      input logic rt_u, input logic rw, input logic [2:0] wr,
                      input logic pe, input logic fl);
    logic e1, e0;
    drive(rs, rt, rs_u, rt_u, rw, wr, pe, fl);
    #1;
    e1 = ((rs_u && m_haz(hq1, 2, rs)) || (rt_u && m_haz(hq1, 2, rt))) && !fl;
    e0 = ((rs_u && m_haz(hq0, 3, rs)) || (rt_u && m_haz(hq0, 3, rt))) && !fl;
    chk("stall_b1",  {31'd0, if1.stall},   {31'd0, e1});
    chk("ifid_b1",   {31'd0, if1.ifid_en}, {31'd0, pe & ~e1});
    chk("pc_b1",     {31'd0, if1.pc_en},   {31'd0, pe & ~e1});
    chk("busy_b1",   {31'd0, if1.sb_busy}, {31'd0, m_busy(hq1)});
    chk("cnt_b1",    {16'd0, if1.stall_cycles}, cnt1);
    chk("stall_b0",  {31'd0, if0.stall},   {31'd0, e0});
    chk("ifid_b0",   {31'd0, if0.ifid_en}, {31'd0, pe & ~e0});
    chk("pc_b0",     {31'd0, if0.pc_en},   {31'd0, pe & ~e0});
    chk("busy_b0",   {31'd0, if0.sb_busy}, {31'd0, m_busy(hq0)});
    chk("cnt_b0",    {16'd0, if0.stall_cycles}, cnt0);
    chk("stall_sat", {31'd0, ifs.stall},   {31'd0, e1});
    chk("cnt_sat",   {30'd0, ifs.stall_cycles}, sat3(cnt1));
    last_st1 = if1.stall;
    last_st0 = if0.stall;
    if (pe && if1.stall) seen1++;
    if (pe && if0.stall) seen0++;
    @(posedge clk);
    if (pe) begin
      if (e1) cnt1++;
      if (e0) cnt0++;
      hq1.push_front((e1 || fl || !rw) ? 4'b0000 : {1'b1, wr});
      hq0.push_front((e0 || fl || !rw) ? 4'b0000 : {1'b1, wr});
      if (hq1.size() > 3) void'(hq1.pop_back());
      if (hq0.size() > 3) void'(hq0.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    hq1.delete();
    hq0.delete();
    cnt1 = 0;
    cnt0 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    // ---- reset state ----
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, if1.stall}, 32'd0);
    chk("rst_busy",  {31'd0, if1.sb_busy}, 32'd0);
    chk("rst_ifid",  {31'd0, if1.ifid_en}, 32'd1);
    chk("rst_pc",    {31'd0, if0.pc_en}, 32'd1);
    chk("rst_cnt",   {16'd0, if0.stall_cycles}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- load-use: write R1, then reader of R1 as rs (held in ID) ----
    seen1 = 0; seen0 = 0;
    step(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(3'd1, 3'd6, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
    chk("lu_seen_b1", seen1, 32'd2);
    chk("lu_seen_b0", seen0, 32'd3);
    chk("lu_cnt_b1", {16'd0, if1.stall_cycles}, 32'd2);
    chk("lu_cnt_b0", {16'd0, if0.stall_cycles}, 32'd3);

    // ---- no real dependency: rt field matches but rt is not used ----
    drain();
    seen1 = 0; seen0 = 0;
    step(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    step(3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step(3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("nodep_seen_b1", seen1, 32'd0);
    chk("nodep_seen_b0", seen0, 32'd0);
    step(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("nodep_busy_b0", {31'd0, if0.sb_busy}, 32'd0);

    // ---- flush with hazard: EX = R3, reader of R3 flushed ----
    drain();
    step(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
    step(3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
    chk("flush_st_b1", {31'd0, last_st1}, 32'd0);
    chk("flush_st_b0", {31'd0, last_st0}, 32'd0);
    // the flushed writer of R7 must not have entered EX
    step(3'd7, 3'd7, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("flush_ex_b1", {31'd0, last_st1}, 32'd0);
    chk("flush_ex_b0", {31'd0, last_st0}, 32'd0);

    // ---- pipe_en low for 4 cycles during a hazard ----
    drain();
    step(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("frz_cnt_b1", {16'd0, if1.stall_cycles}, 32'd2);
    chk("frz_st_b1", {31'd0, last_st1}, 32'd1);
    seen1 = 0; seen0 = 0;
    for (int i = 0; i < 4; i++) step(3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("frz_rem_b1", seen1, 32'd2);
    chk("frz_rem_b0", seen0, 32'd3);
    chk("sat_ones", {30'd0, ifs.stall_cycles}, 32'd3);

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      step(3'($urandom_range(3, 0)), 3'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)), 3'($urandom_range(3, 0)),
           ($urandom_range(9, 0) < 8), ($urandom_range(9, 0) == 0));
    end
    chk("sat_hold", {30'd0, ifs.stall_cycles}, 32'd3);

    // ---- async reset mid-stall ----
    drain();
    step(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
    drive(3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    #1;
    chk("pre_rst_st", {31'd0, if1.stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_st_b1",   {31'd0, if1.stall}, 32'd0);
    chk("arst_st_b0",   {31'd0, if0.stall}, 32'd0);
    chk("arst_busy_b1", {31'd0, if1.sb_busy}, 32'd0);
    chk("arst_cnt_b1",  {16'd0, if1.stall_cycles}, 32'd0);
    chk("arst_cnt_sat", {30'd0, ifs.stall_cycles}, 32'd0);
    chk("arst_ifid",    {31'd0, if1.ifid_en}, 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("post_rst_st", {31'd0, last_st1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard controller for the five-stage WISC-SP13 core. It owns the stall signal consumed by the ID/EX register, which injects a NOP on stall, and produces the matching IF/ID and PC hold enables. It tracks in-flight register writers in a three-entry scoreboard that mirrors the EX, MEM and WB stages, and detects RAW hazards against the instruction currently in ID. The core has no forwarding, so stalls persist until the producer has passed.

## Interface
Parameters:
- WB_BYPASS, 1: 1 = register file writes before it reads in the same cycle, so the WB entry never causes a hazard; 0 = the WB entry is also checked.
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_instr  in  16  instruction in ID; rs = [10:8], rt = [7:5].
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- id_reg_write  in  1  ID instruction writes the register file.
- id_wr_reg  in  3  destination register of the ID instruction (already muxed by reg_dst).
- pipe_en  in  1  global pipeline advance; 0 freezes all stages (memory busy).
- flush  in  1  branch/jump taken in EX; squashes the IF and ID instructions.
- stall  out  1  to the ID/EX stall input; inject NOP into EX.
- ifid_en  out  1  IF/ID register enable.
- pc_en  out  1  PC register enable.
- sb_busy  out  1  any scoreboard entry valid.
- stall_cycles  out  CNT_W  saturating count of cycles with stall & pipe_en.

## Operation
- Scoreboard entries EX, MEM and WB each hold {valid, reg[2:0]}. They reset to invalid, reg 0.
- Hazard, combinational:
  - match(e, r) = e.valid & (e.reg == r).
  - Checked entries are EX and MEM, plus WB when WB_BYPASS = 0.
  - haz = (id_rs_used & any match on rs) | (id_rt_used & any match on rt).
- stall = haz & ~flush. Flush wins because a squashed ID instruction must not hold the pipe.
- ifid_en = pc_en = pipe_en & ~stall.
- Update when pipe_en = 1:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= (stall | flush) ? invalid : {id_reg_write, id_wr_reg}.
  - With id_reg_write = 0, EX is loaded invalid.
- Update when pipe_en = 0: all entries hold and stall_cycles holds. The stall output still reflects the current hazard.
- Writes to R0 are tracked like any other register, because R0 is a real register in this ISA.
- stall_cycles increments on each edge with stall & pipe_en and saturates at all-ones. It never wraps.
- Reset mid-stall clears the scoreboard asynchronously, so stall drops in the same cycle rst asserts.

## Timing
- Reset values: stall 0, sb_busy 0, stall_cycles 0. ifid_en and pc_en equal pipe_en.
- stall has zero-cycle latency from ID inputs and a one-edge latency from scoreboard changes.
- A producer immediately followed by a dependent instruction stalls for 2 cycles with WB_BYPASS = 1, or 3 cycles with WB_BYPASS = 0, given pipe_en held 1. With one independent instruction between them, the stall is 1 or 2 cycles respectively.
- Each cycle of pipe_en = 0 extends the stall by one cycle without corrupting the scoreboard.
- Simultaneous flush and haz: stall = 0 and EX is loaded invalid.
- Simultaneous stall and pipe_en = 0: nothing advances and the counter does not increment.

## Structure
- The shared package wisc_pkg holds:
  - REG_W = 3;
  - the instruction field positions RS_HI/RS_LO and RT_HI/RT_LO;
  - the NOP encoding 16'b00001_00000000000;
  - the sb_entry_t typedef {valid, reg}.
- One sub-module, hazard_cmp: compares one source register against the checked entries and returns a match. It is instantiated twice, once for rs and once for rt.
- The scoreboard shift registers and the counter live in hazard_ctl itself.

## Test plan
- Load-use: write R1, then ADD reading R1 as rs, WB_BYPASS = 1 -> stall high for exactly 2 cycles, ifid_en = pc_en = 0 during the stall, stall_cycles = 2, EX invalid while stalling.
- Same sequence with WB_BYPASS = 0 -> stall for 3 cycles, stall_cycles = 3.
- No real dependency: write R2, then an instruction reading R3 with rt_used = 0 and rt field = 2 -> stall never asserts and the EX, MEM, WB entries advance as {1,2}, then invalid.
- Flush with hazard: EX holds {1,3}, ID reads R3 while flush = 1 -> stall = 0, and EX is invalid after the edge.
- pipe_en held 0 for 4 cycles during a hazard -> scoreboard frozen and counter frozen; after release the stall lasts the normal remaining cycles.
- Async rst pulse mid-stall -> stall and sb_busy go 0 immediately and stall_cycles = 0. Separately, force the counter to all-ones and stall once more -> the counter stays at all-ones.
